uncache_mem_bridge: RTL and testbench

- Sits directly downstream of the LSU uncached-memory port.
- Accepts one LSU uncached request at a time: size in bytes is 1/2/4/8 (size code 0..3), byte address, and write data right-aligned.
- Converts it into a single-beat transaction on the doubleword-aligned system bus, with byte-lane steering and write strobes.
- For loads, shifts the bus read data back down to bit 0, zero-extends it and returns it to the LSU. Store acks are absorbed locally.

---
 rtl/uncache_mem_bridge_pkg.sv | 43 ++++
 rtl/uncache_lane_align.sv | 37 +++
 rtl/uncache_mem_bridge.sv | 196 +++++++++++++++++++
 tb/tb_uncache_mem_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncache_mem_bridge_pkg.sv
// Shared definitions for the uncached LSU-to-bus bridge: size codes, FSM encodings and
// byte-lane strobe masks, plus helpers used by the lane aligner.
package uncache_mem_bridge_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_RET  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [7:0] WSTRB_B = 8'h01;
  localparam logic [7:0] WSTRB_H = 8'h03;
  localparam logic [7:0] WSTRB_W = 8'h0F;
  localparam logic [7:0] WSTRB_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = WSTRB_B;
      SZ_H:    m = WSTRB_H;
      SZ_W:    m = WSTRB_W;
      default: m = WSTRB_D;
    endcase
    return m;
  endfunction

  // Byte mask expanded to a 64-bit bit mask.
  function automatic logic [63:0] data_mask(input logic [1:0] size);
    logic [7:0]  m;
    logic [63:0] d;
    m = size_mask(size);
    for (int i = 0; i < 8; i++) begin
      d[i*8 +: 8] = {8{m[i]}};
    end
    return d;
  endfunction

endpackage

// File: rtl/uncache_lane_align.sv
// Combinational byte-lane logic: misalignment detect, write strobe/data steering and
// read-data shift-down with zero-extension to the access size.
module uncache_lane_align
  import uncache_mem_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic        misaligned,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_lane
);

  logic [5:0]  shamt;
  logic [63:0] mask;

  assign shamt = {offset, 3'b000};
  assign mask  = data_mask(size);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  assign wstrb      = size_mask(size) << offset;
  // Mask before shifting so lanes outside the access always carry zero.
  assign wdata_lane = (wdata & mask) << shamt;
  assign rdata_lane = (rdata >> shamt) & mask;

endmodule

// File: rtl/uncache_mem_bridge.sv
// Converts single LSU uncached accesses into single-beat doubleword bus transactions.
// access_err_o is decoded from registered state so it lands in the completing cycle.
module uncache_mem_bridge
  import uncache_mem_bridge_pkg::*;
#(
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter logic [63:0] ERR_RDATA      = 64'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uncache_mem_vld_i,
  output logic                      uncache_mem_ready_o,
  input  logic                      uncache_mem_write_i,
  input  logic [2:0]                uncache_mem_size_i,
  input  logic [63:0]               uncache_mem_addr_i,
  input  logic [63:0]               uncache_mem_wdata_i,
  output logic                      uncache_mem_resp_vld_o,
  input  logic                      uncache_mem_resp_rdy_i,
  output logic [63:0]               uncache_mem_resp_data_o,
  output logic                      bus_req_vld_o,
  input  logic                      bus_req_rdy_i,
  output logic                      bus_req_write_o,
  output logic [BUS_ADDR_WIDTH-1:0] bus_req_addr_o,
  output logic [7:0]                bus_req_wstrb_o,
  output logic [63:0]               bus_req_wdata_o,
  input  logic                      bus_resp_vld_i,
  output logic                      bus_resp_rdy_o,
  input  logic [63:0]               bus_resp_data_i,
  input  logic                      bus_resp_err_i,
  output logic                      access_err_o
);

  logic [2:0]                state_q, state_d;
  logic                      write_q, write_d;
  logic [1:0]                size_q, size_d;
  logic [2:0]                offset_q, offset_d;
  logic                      err_q, err_d;
  logic                      bus_req_vld_q, bus_req_vld_d;
  logic                      bus_req_write_q, bus_req_write_d;
  logic [BUS_ADDR_WIDTH-1:0] bus_req_addr_q, bus_req_addr_d;
  logic [7:0]                bus_req_wstrb_q, bus_req_wstrb_d;
  logic [63:0]               bus_req_wdata_q, bus_req_wdata_d;
  logic                      resp_vld_q, resp_vld_d;
  logic [63:0]               resp_data_q, resp_data_d;

  logic [1:0]  sel_size;
  logic [2:0]  sel_offset;
  logic        misaligned;
  logic [7:0]  lane_wstrb;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;
  logic        unused_in;

  assign unused_in = ^{uncache_mem_size_i[2], uncache_mem_addr_i[63:BUS_ADDR_WIDTH]};

  // The aligner looks at the incoming request while idle and the latched one afterwards.
  assign sel_size   = (state_q == ST_IDLE) ? uncache_mem_size_i[1:0] : size_q;
  assign sel_offset = (state_q == ST_IDLE) ? uncache_mem_addr_i[2:0] : offset_q;

  uncache_lane_align u_lane_align (
    .size       (sel_size),
    .offset     (sel_offset),
    .wdata      (uncache_mem_wdata_i),
    .rdata      (bus_resp_data_i),
    .misaligned (misaligned),
    .wstrb      (lane_wstrb),
    .wdata_lane (lane_wdata),
    .rdata_lane (lane_rdata)
  );

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    size_d          = size_q;
    offset_d        = offset_q;
    err_d           = err_q;
    bus_req_vld_d   = bus_req_vld_q;
    bus_req_write_d = bus_req_write_q;
    bus_req_addr_d  = bus_req_addr_q;
    bus_req_wstrb_d = bus_req_wstrb_q;
    bus_req_wdata_d = bus_req_wdata_q;
    resp_vld_d      = resp_vld_q;
    resp_data_d     = resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (uncache_mem_vld_i) begin
          write_d  = uncache_mem_write_i;
          size_d   = uncache_mem_size_i[1:0];
          offset_d = uncache_mem_addr_i[2:0];
          err_d    = 1'b0;
          if (misaligned) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            if (!uncache_mem_write_i) begin
              resp_vld_d  = 1'b1;
              resp_data_d = ERR_RDATA;
            end
          end else begin
            state_d         = ST_REQ;
            bus_req_vld_d   = 1'b1;
            bus_req_write_d = uncache_mem_write_i;
            bus_req_addr_d  = {uncache_mem_addr_i[BUS_ADDR_WIDTH-1:3], 3'b000};
            bus_req_wstrb_d = uncache_mem_write_i ? lane_wstrb : 8'hFF;
            bus_req_wdata_d = uncache_mem_write_i ? lane_wdata : 64'h0;
          end
        end
      end
      ST_REQ: begin
        if (bus_req_rdy_i) begin
          bus_req_vld_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_resp_vld_i) begin
          if (write_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_RET;
            resp_vld_d  = 1'b1;
            resp_data_d = bus_resp_err_i ? ERR_RDATA : lane_rdata;
            err_d       = bus_resp_err_i;
          end
        end
      end
      ST_RET: begin
        if (uncache_mem_resp_rdy_i) begin
          resp_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (write_q) begin
          state_d = ST_IDLE;
        end else if (uncache_mem_resp_rdy_i) begin
          resp_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      write_q         <= 1'b0;
      size_q          <= 2'd0;
      offset_q        <= 3'd0;
      err_q           <= 1'b0;
      bus_req_vld_q   <= 1'b0;
      bus_req_write_q <= 1'b0;
      bus_req_addr_q  <= '0;
      bus_req_wstrb_q <= 8'h0;
      bus_req_wdata_q <= 64'h0;
      resp_vld_q      <= 1'b0;
      resp_data_q     <= 64'h0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      size_q          <= size_d;
      offset_q        <= offset_d;
      err_q           <= err_d;
      bus_req_vld_q   <= bus_req_vld_d;
      bus_req_write_q <= bus_req_write_d;
      bus_req_addr_q  <= bus_req_addr_d;
      bus_req_wstrb_q <= bus_req_wstrb_d;
      bus_req_wdata_q <= bus_req_wdata_d;
      resp_vld_q      <= resp_vld_d;
      resp_data_q     <= resp_data_d;
    end
  end

  assign uncache_mem_ready_o     = (state_q == ST_IDLE);
  assign bus_resp_rdy_o          = (state_q == ST_RESP);
  assign uncache_mem_resp_vld_o  = resp_vld_q;
  assign uncache_mem_resp_data_o = resp_data_q;
  assign bus_req_vld_o           = bus_req_vld_q;
  assign bus_req_write_o         = bus_req_write_q;
  assign bus_req_addr_o          = bus_req_addr_q;
  assign bus_req_wstrb_o         = bus_req_wstrb_q;
  assign bus_req_wdata_o         = bus_req_wdata_q;

  // Completion cycles: misaligned store drop, store bus-error ack, load handshake with error.
  always_comb begin
    access_err_o = 1'b0;
    case (state_q)
      ST_ERR:  access_err_o = write_q | uncache_mem_resp_rdy_i;
      ST_RET:  access_err_o = err_q & uncache_mem_resp_rdy_i;
      ST_RESP: access_err_o = write_q & bus_resp_vld_i & bus_resp_err_i;
      default: access_err_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uncache_mem_bridge.sv
// Directed bench for uncache_mem_bridge: a table of single transactions with immediate
// handshakes, then hand-written stall, back-pressure and mid-transaction reset sequences.
module tb_uncache_mem_bridge;

  localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        ready;
  logic        write = 1'b0;
  logic [2:0]  size = 3'd0;
  logic [63:0] addr = 64'h0;
  logic [63:0] wdata = 64'h0;
  logic        resp_vld;
  logic        resp_rdy = 1'b1;
  logic [63:0] resp_data;
  logic        breq_vld;
  logic        breq_rdy = 1'b1;
  logic        breq_write;
  logic [31:0] breq_addr;
  logic [7:0]  breq_wstrb;
  logic [63:0] breq_wdata;
  logic        bresp_vld = 1'b0;
  logic        bresp_rdy;
  logic [63:0] bresp_data = 64'h0;
  logic        bresp_err = 1'b0;
  logic        acc_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uncache_mem_bridge #(
    .BUS_ADDR_WIDTH (32),
    .ERR_RDATA      (ERR_DATA)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .uncache_mem_vld_i       (vld),
    .uncache_mem_ready_o     (ready),
    .uncache_mem_write_i     (write),
    .uncache_mem_size_i      (size),
    .uncache_mem_addr_i      (addr),
    .uncache_mem_wdata_i     (wdata),
    .uncache_mem_resp_vld_o  (resp_vld),
    .uncache_mem_resp_rdy_i  (resp_rdy),
    .uncache_mem_resp_data_o (resp_data),
    .bus_req_vld_o           (breq_vld),
    .bus_req_rdy_i           (breq_rdy),
    .bus_req_write_o         (breq_write),
    .bus_req_addr_o          (breq_addr),
    .bus_req_wstrb_o         (breq_wstrb),
    .bus_req_wdata_o         (breq_wdata),
    .bus_resp_vld_i          (bresp_vld),
    .bus_resp_rdy_o          (bresp_rdy),
    .bus_resp_data_i         (bresp_data),
    .bus_resp_err_i          (bresp_err),
    .access_err_o            (acc_err)
  );

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        berr;
    logic        mis;
    logic [31:0] eaddr;
    logic [7:0]  ewstrb;
    logic [63:0] ewdata;
    logic [63:0] edata;
    logic        eerr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    vld = 1'b1; write = v.write; size = v.size; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    check({t, "_ready"}, 64'(ready), 64'd1);
    tick();
    vld = 1'b0;
    @(negedge clk);
    check({t, "_breq_vld"}, 64'(breq_vld), 64'(!v.mis));
    if (v.mis) begin
      check({t, "_resp_vld"}, 64'(resp_vld), 64'(!v.write));
      if (!v.write) check({t, "_data"}, resp_data, v.edata);
      check({t, "_acc_err"}, 64'(acc_err), 64'd1);
    end else begin
      check({t, "_addr"}, 64'(breq_addr), 64'(v.eaddr));
      check({t, "_wstrb"}, 64'(breq_wstrb), 64'(v.ewstrb));
      check({t, "_wdata"}, breq_wdata, v.ewdata);
      check({t, "_write"}, 64'(breq_write), 64'(v.write));
      tick();
      bresp_vld = 1'b1; bresp_data = v.rdata; bresp_err = v.berr;
      @(negedge clk);
      check({t, "_bresp_rdy"}, 64'(bresp_rdy), 64'd1);
      if (v.write) check({t, "_wr_acc_err"}, 64'(acc_err), 64'(v.eerr));
      tick();
      bresp_vld = 1'b0; bresp_err = 1'b0;
      @(negedge clk);
      check({t, "_resp_vld"}, 64'(resp_vld), 64'(!v.write));
      if (!v.write) begin
        check({t, "_data"}, resp_data, v.edata);
        check({t, "_rd_acc_err"}, 64'(acc_err), 64'(v.eerr));
      end
    end
    if (!(v.mis == 1'b0 && v.write == 1'b1)) tick();
    @(negedge clk);
    check({t, "_ready_after"}, 64'(ready), 64'd1);
    check({t, "_acc_err_after"}, 64'(acc_err), 64'd0);
    tick();
  endtask

  initial begin
    //          wr   size  addr                   wdata                  rdata                  berr mis eaddr         ewstrb ewdata                 edata                  eerr
    vecs[0]  = '{1'b0, 3'd2, 64'h8000_0004,         64'h0,                 64'hAABBCCDD_11223344, 1'b0, 1'b0, 32'h8000_0000, 8'hFF, 64'h0,                 64'h00000000_AABBCCDD, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 64'h1003,              64'h5A,                64'h0,                 1'b0, 1'b0, 32'h0000_1000, 8'h08, 64'h00000000_5A000000, 64'h0,                 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 64'h1001,              64'h1234,              64'h0,                 1'b0, 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0,                 1'b1};
    vecs[3]  = '{1'b0, 3'd0, 64'h3005,              64'h0,                 64'h01234567_89ABCDEF, 1'b0, 1'b0, 32'h0000_3000, 8'hFF, 64'h0,                 64'h45,                1'b0};
    vecs[4]  = '{1'b0, 3'd1, 64'h4006,              64'h0,                 64'h01234567_89ABCDEF, 1'b0, 1'b0, 32'h0000_4000, 8'hFF, 64'h0,                 64'h0123,              1'b0};
    vecs[5]  = '{1'b1, 3'd2, 64'h5004,              64'hCAFEBABE,          64'h0,                 1'b0, 1'b0, 32'h0000_5000, 8'hF0, 64'hCAFEBABE_00000000, 64'h0,                 1'b0};
    vecs[6]  = '{1'b1, 3'd3, 64'h6000,              64'h11223344_55667788, 64'h0,                 1'b1, 1'b0, 32'h0000_6000, 8'hFF, 64'h11223344_55667788, 64'h0,                 1'b1};
    vecs[7]  = '{1'b0, 3'd2, 64'h7002,              64'h0,                 64'h0,                 1'b0, 1'b1, 32'h0,         8'h00, 64'h0,                 ERR_DATA,              1'b1};
    vecs[8]  = '{1'b1, 3'd1, 64'h1002,              64'hBEEF,              64'h0,                 1'b0, 1'b0, 32'h0000_1000, 8'h0C, 64'h00000000_BEEF0000, 64'h0,                 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 64'h1_2345_6788,       64'h0,                 64'hFEDCBA98_76543210, 1'b0, 1'b0, 32'h2345_6788, 8'hFF, 64'h0,                 64'hFEDCBA98_76543210, 1'b0};
    vecs[10] = '{1'b0, 3'd5, 64'h10,                64'h0,                 64'h11112222_3333ABCD, 1'b0, 1'b0, 32'h0000_0010, 8'hFF, 64'h0,                 64'hABCD,              1'b0};

    // Reset state
    #2;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_breq_vld", 64'(breq_vld), 64'd0);
    check("rst_resp_vld", 64'(resp_vld), 64'd0);
    check("rst_acc_err", 64'(acc_err), 64'd0);
    check("rst_wstrb", 64'(breq_wstrb), 64'd0);
    check("rst_bresp_rdy", 64'(bresp_rdy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Bus request stalled five cycles, then an error response on a double load.
    vld = 1'b1; write = 1'b0; size = 3'd3; addr = 64'h2000; breq_rdy = 1'b0;
    tick();
    vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld", 64'(breq_vld), 64'd1);
      check("stall_addr", 64'(breq_addr), 64'h2000);
      check("stall_wstrb", 64'(breq_wstrb), 64'hFF);
      check("stall_write", 64'(breq_write), 64'd0);
      tick();
    end
    breq_rdy = 1'b1;
    @(negedge clk);
    check("stall_vld_last", 64'(breq_vld), 64'd1);
    tick();
    bresp_vld = 1'b1; bresp_err = 1'b1; bresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("stall_acc_err_resp", 64'(acc_err), 64'd0);
    tick();
    bresp_vld = 1'b0; bresp_err = 1'b0;
    @(negedge clk);
    check("stall_resp_vld", 64'(resp_vld), 64'd1);
    check("stall_data", resp_data, ERR_DATA);
    check("stall_acc_err", 64'(acc_err), 64'd1);
    tick();
    @(negedge clk);
    check("stall_ready", 64'(ready), 64'd1);
    check("stall_acc_err_clr", 64'(acc_err), 64'd0);
    tick();

    // LSU back-pressure on a load while a second request (byte store) waits on vld.
    vld = 1'b1; write = 1'b0; size = 3'd2; addr = 64'h8; resp_rdy = 1'b0;
    tick();
    write = 1'b1; size = 3'd0; addr = 64'h9; wdata = 64'hA5;
    tick();
    tick();
    bresp_vld = 1'b1; bresp_data = 64'h11111111_22222222;
    tick();
    bresp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_resp_vld", 64'(resp_vld), 64'd1);
      check("bp_data", resp_data, 64'h22222222);
      check("bp_ready", 64'(ready), 64'd0);
      check("bp_acc_err", 64'(acc_err), 64'd0);
      tick();
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_hs_vld", 64'(resp_vld), 64'd1);
    check("bp_hs_ready", 64'(ready), 64'd0);
    tick();
    @(negedge clk);
    check("bp_second_ready", 64'(ready), 64'd1);
    check("bp_resp_vld_clr", 64'(resp_vld), 64'd0);
    tick();
    vld = 1'b0;
    @(negedge clk);
    check("bp_second_breq", 64'(breq_vld), 64'd1);
    check("bp_second_wstrb", 64'(breq_wstrb), 64'h02);
    check("bp_second_wdata", breq_wdata, 64'hA500);
    check("bp_second_write", 64'(breq_write), 64'd1);
    tick();
    bresp_vld = 1'b1;
    tick();
    bresp_vld = 1'b0;
    @(negedge clk);
    check("bp_second_done", 64'(ready), 64'd1);
    check("bp_second_no_resp", 64'(resp_vld), 64'd0);
    tick();

    // Reset asserted while waiting in RESP; a stray bus response afterwards is ignored.
    vld = 1'b1; write = 1'b0; size = 3'd3; addr = 64'h4000;
    tick();
    vld = 1'b0;
    tick();
    @(negedge clk);
    check("rr_in_resp", 64'(bresp_rdy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rr_ready", 64'(ready), 64'd1);
    check("rr_breq_vld", 64'(breq_vld), 64'd0);
    check("rr_breq_addr", 64'(breq_addr), 64'd0);
    check("rr_bresp_rdy", 64'(bresp_rdy), 64'd0);
    check("rr_resp_vld", 64'(resp_vld), 64'd0);
    check("rr_acc_err", 64'(acc_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bresp_vld = 1'b1; bresp_data = 64'h1234;
    @(negedge clk);
    check("rr_stray_rdy", 64'(bresp_rdy), 64'd0);
    tick();
    bresp_vld = 1'b0;
    @(negedge clk);
    check("rr_stray_resp_vld", 64'(resp_vld), 64'd0);
    check("rr_stray_ready", 64'(ready), 64'd1);
    check("rr_stray_data", resp_data, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
